// File: rtl/md_pos_pkg.sv
// Shared types for the double-buffered particle position store.
package md_pos_pkg;

  // One particle position, x in the low word.
  typedef struct packed {
    logic [31:0] posz;
    logic [31:0] posy;
    logic [31:0] posx;
  } pos_t;

  // Bank-swap sequencer states.
  typedef enum logic [1:0] {
    StRun,
    StDrain0,
    StDrain1,
    StSwap
  } swap_state_e;

  localparam int unsigned DEFAULT_PARTICLE_NUM = 220;

endpackage

// File: rtl/pos_cell_pingpong_if.sv
// Read, write and swap signals of the ping-pong position store.
interface pos_cell_pingpong_if
  import md_pos_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = $bits(pos_t),
  parameter int unsigned ADDR_WIDTH = 8
) ();

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] rd_num_particles;
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  swap_req;
  logic                  swap_done;
  logic                  active_bank;
  logic                  overflow;

  modport master (
    output rd_en, rd_addr, wr_valid, wr_data, swap_req,
    input  rd_data, rd_valid, rd_num_particles, wr_ready, swap_done, active_bank, overflow
  );

  modport slave (
    input  rd_en, rd_addr, wr_valid, wr_data, swap_req,
    output rd_data, rd_valid, rd_num_particles, wr_ready, swap_done, active_bank, overflow
  );

endinterface

// File: rtl/pos_bank_ram.sv
// Simple dual-port RAM bank: one write port, one read port with registered
// address and registered data (2-cycle read latency). Contents are not reset.
module pos_bank_ram #(
  parameter int unsigned DATA_WIDTH = 96,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DEPTH      = 220
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] raddr_q;
  logic                  re_q;

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: register the address, then register the array output.
  always_ff @(posedge clk) begin
    re_q <= re;
    if (re) begin
      raddr_q <= raddr;
    end
    if (re_q) begin
      rdata <= mem[raddr_q];
    end
  end

endmodule

// File: rtl/pos_cell_pingpong.sv
// Double-buffered particle position store. Reads come from the active bank,
// writes append to the shadow bank, and a swap exchanges them after letting
// in-flight reads drain.
module pos_cell_pingpong
  import md_pos_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = $bits(pos_t),
  parameter int unsigned PARTICLE_NUM = DEFAULT_PARTICLE_NUM,
  // Must satisfy 2**ADDR_WIDTH > PARTICLE_NUM so a full count fits.
  parameter int unsigned ADDR_WIDTH   = 8
) (
  input logic               clk,
  input logic               rst,
  pos_cell_pingpong_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] FULL_PTR = ADDR_WIDTH'(PARTICLE_NUM);

  swap_state_e           state_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] num_q;
  logic                  active_bank_q;
  logic                  overflow_q;
  logic                  wr_ready_q;
  logic                  swap_done_q;

  logic                  rd_v1_q, rd_bank1_q, rd_inr1_q;
  logic                  rd_v2_q, rd_bank2_q, rd_inr2_q;

  logic                  accept;
  logic                  ovf_set;
  logic                  rd_take;
  logic [ADDR_WIDTH-1:0] wr_ptr_run;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;

  assign accept     = bus.wr_valid && wr_ready_q;
  assign ovf_set    = bus.wr_valid && (state_q == StRun) && (wr_ptr_q == FULL_PTR);
  assign rd_take    = bus.rd_en && (state_q == StRun);
  assign wr_ptr_run = wr_ptr_q + ADDR_WIDTH'(accept);

  // Swap sequencer with write pointer, count and status outputs.
  // wr_ready is registered from the next-cycle state and pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StRun;
      wr_ptr_q      <= '0;
      num_q         <= '0;
      active_bank_q <= 1'b0;
      overflow_q    <= 1'b0;
      wr_ready_q    <= 1'b0;
      swap_done_q   <= 1'b0;
    end else begin
      swap_done_q <= 1'b0;
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end
      unique case (state_q)
        StRun: begin
          wr_ptr_q <= wr_ptr_run;
          if (bus.swap_req) begin
            state_q    <= StDrain0;
            wr_ready_q <= 1'b0;
          end else begin
            wr_ready_q <= (wr_ptr_run < FULL_PTR);
          end
        end
        StDrain0: begin
          state_q    <= StDrain1;
          wr_ready_q <= 1'b0;
        end
        // Bank exchange becomes visible during the SWAP cycle.
        StDrain1: begin
          state_q       <= StSwap;
          wr_ready_q    <= 1'b0;
          active_bank_q <= ~active_bank_q;
          num_q         <= wr_ptr_q;
          wr_ptr_q      <= '0;
          overflow_q    <= 1'b0;
          swap_done_q   <= 1'b1;
        end
        StSwap: begin
          state_q    <= StRun;
          wr_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= StRun;
          wr_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Read side-band pipeline tracking the RAM's two register stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_v1_q    <= 1'b0;
      rd_bank1_q <= 1'b0;
      rd_inr1_q  <= 1'b0;
      rd_v2_q    <= 1'b0;
      rd_bank2_q <= 1'b0;
      rd_inr2_q  <= 1'b0;
    end else begin
      rd_v1_q    <= rd_take;
      rd_bank1_q <= active_bank_q;
      rd_inr1_q  <= (bus.rd_addr < num_q);
      rd_v2_q    <= rd_v1_q;
      rd_bank2_q <= rd_bank1_q;
      rd_inr2_q  <= rd_inr1_q;
    end
  end

  pos_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (PARTICLE_NUM)
  ) u_bank0 (
    .clk   (clk),
    .we    (accept && active_bank_q),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .re    (rd_take),
    .raddr (bus.rd_addr),
    .rdata (rdata0)
  );

  pos_bank_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (PARTICLE_NUM)
  ) u_bank1 (
    .clk   (clk),
    .we    (accept && !active_bank_q),
    .waddr (wr_ptr_q),
    .wdata (bus.wr_data),
    .re    (rd_take),
    .raddr (bus.rd_addr),
    .rdata (rdata1)
  );

  // Out-of-range addresses and idle cycles read as zero.
  assign bus.rd_data          = (rd_v2_q && rd_inr2_q) ? (rd_bank2_q ? rdata1 : rdata0) : '0;
  assign bus.rd_valid         = rd_v2_q;
  assign bus.rd_num_particles = num_q;
  assign bus.wr_ready         = wr_ready_q;
  assign bus.swap_done        = swap_done_q;
  assign bus.active_bank      = active_bank_q;
  assign bus.overflow         = overflow_q;

endmodule

// File: tb/tb_pos_cell_pingpong.sv
// Directed self-checking bench for pos_cell_pingpong.
module tb_pos_cell_pingpong;

  localparam int unsigned DW = 96;
  localparam int unsigned AW = 8;
  localparam int unsigned PN = 220;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  pos_cell_pingpong_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  pos_cell_pingpong #(
    .DATA_WIDTH   (DW),
    .PARTICLE_NUM (PN),
    .ADDR_WIDTH   (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] data_of(input int i);
    return {32'hCAFE0000 + 32'(i), 32'h5A5A5A5A, 32'(i)};
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one read and check the result two edges later.
  task automatic read_chk(input string tag, input int addr, input logic [DW-1:0] want);
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(addr);
    tick();
    bus.rd_en = 1'b0;
    tick();
    check({tag, " valid"}, DW'(bus.rd_valid), DW'(1));
    check({tag, " data"}, bus.rd_data, want);
  endtask

  task automatic do_swap(input string tag, input logic exp_bank, input int exp_num);
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    check({tag, " drain0 done"}, DW'(bus.swap_done), DW'(0));
    check({tag, " drain0 ready"}, DW'(bus.wr_ready), DW'(0));
    tick();
    check({tag, " drain1 done"}, DW'(bus.swap_done), DW'(0));
    tick();
    check({tag, " swap done"}, DW'(bus.swap_done), DW'(1));
    check({tag, " bank"}, DW'(bus.active_bank), DW'(exp_bank));
    check({tag, " num"}, DW'(bus.rd_num_particles), DW'(exp_num));
    check({tag, " ovf clr"}, DW'(bus.overflow), DW'(0));
    tick();
    check({tag, " done pulse"}, DW'(bus.swap_done), DW'(0));
    check({tag, " ready back"}, DW'(bus.wr_ready), DW'(1));
  endtask

  initial begin
    #2_000_000;
    n_vec++;
    n_err++;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.swap_req = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst rd_data", bus.rd_data, '0);
    check("rst rd_valid", DW'(bus.rd_valid), DW'(0));
    check("rst num", DW'(bus.rd_num_particles), DW'(0));
    check("rst wr_ready", DW'(bus.wr_ready), DW'(0));
    check("rst swap_done", DW'(bus.swap_done), DW'(0));
    check("rst bank", DW'(bus.active_bank), DW'(0));
    check("rst overflow", DW'(bus.overflow), DW'(0));
    rst = 1'b0;
    #1;
    check("ready first cycle", DW'(bus.wr_ready), DW'(0));
    tick();
    check("ready second cycle", DW'(bus.wr_ready), DW'(1));

    // Read of empty bank: latency 2, zero data.
    bus.rd_en   = 1'b1;
    bus.rd_addr = 8'd0;
    tick();
    bus.rd_en = 1'b0;
    check("empty rd T+1", DW'(bus.rd_valid), DW'(0));
    tick();
    check("empty rd valid", DW'(bus.rd_valid), DW'(1));
    check("empty rd data", bus.rd_data, '0);
    tick();
    check("empty rd gone", DW'(bus.rd_valid), DW'(0));

    // Three beats, then swap.
    for (int i = 1; i <= 3; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = DW'(i);
      tick();
    end
    bus.wr_valid = 1'b0;
    do_swap("swap1", 1'b1, 3);
    read_chk("b1 a0", 0, DW'(1));
    read_chk("b1 a1", 1, DW'(2));
    read_chk("b1 a2", 2, DW'(3));
    read_chk("b1 a3 oob", 3, '0);

    // Fill the shadow bank, then one beat too many.
    for (int i = 0; i < int'(PN); i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = data_of(i);
      tick();
    end
    check("full ready", DW'(bus.wr_ready), DW'(0));
    check("full no ovf", DW'(bus.overflow), DW'(0));
    bus.wr_data = 96'hDEAD;
    tick();
    bus.wr_valid = 1'b0;
    check("ovf set", DW'(bus.overflow), DW'(1));
    tick();
    check("ovf sticky", DW'(bus.overflow), DW'(1));
    do_swap("swap2", 1'b0, int'(PN));
    read_chk("b0 a0", 0, data_of(0));
    read_chk("b0 a219", 219, data_of(219));
    read_chk("b0 a220 oob", 220, '0);

    // Read in the swap_req cycle completes from the old bank; drain reads are dropped.
    bus.rd_en    = 1'b1;
    bus.rd_addr  = 8'd5;
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    check("drain0 valid", DW'(bus.rd_valid), DW'(0));
    tick();
    check("drain1 valid", DW'(bus.rd_valid), DW'(1));
    check("drain1 data", bus.rd_data, data_of(5));
    tick();
    check("swap3 done", DW'(bus.swap_done), DW'(1));
    check("swap3 bank", DW'(bus.active_bank), DW'(1));
    check("swap3 num", DW'(bus.rd_num_particles), DW'(0));
    check("swap cyc valid", DW'(bus.rd_valid), DW'(0));
    tick();
    check("post swap valid a", DW'(bus.rd_valid), DW'(0));
    bus.rd_en = 1'b0;
    tick();
    check("post swap valid b", DW'(bus.rd_valid), DW'(0));
    read_chk("b1 empty a0", 0, '0);

    // Reset during DRAIN1 with a read in flight.
    bus.rd_en    = 1'b1;
    bus.rd_addr  = 8'd0;
    bus.swap_req = 1'b1;
    tick();
    bus.rd_en    = 1'b0;
    bus.swap_req = 1'b0;
    tick();
    check("pre-rst valid", DW'(bus.rd_valid), DW'(1));
    rst = 1'b1;
    #1;
    check("mid rst valid", DW'(bus.rd_valid), DW'(0));
    check("mid rst bank", DW'(bus.active_bank), DW'(0));
    check("mid rst num", DW'(bus.rd_num_particles), DW'(0));
    check("mid rst ready", DW'(bus.wr_ready), DW'(0));
    tick();
    check("mid rst no done", DW'(bus.swap_done), DW'(0));
    rst = 1'b0;
    tick();
    check("rst2 no done", DW'(bus.swap_done), DW'(0));
    check("rst2 ready", DW'(bus.wr_ready), DW'(1));

    // Back-to-back swaps with no writes.
    do_swap("bb1", 1'b1, 0);
    read_chk("bb1 a0", 0, '0);
    do_swap("bb2", 1'b0, 0);
    read_chk("bb2 a5", 5, '0);

    // Simultaneous read and write target different banks.
    bus.rd_en    = 1'b1;
    bus.rd_addr  = 8'd0;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 96'h77;
    tick();
    bus.rd_en    = 1'b0;
    bus.wr_valid = 1'b0;
    tick();
    check("rw valid", DW'(bus.rd_valid), DW'(1));
    check("rw data", bus.rd_data, '0);
    do_swap("swap4", 1'b1, 1);
    read_chk("b1 new a0", 0, 96'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
